tick_scheduler: RTL
===================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of tick channels.
REQ-002 SHALL have parameter PRESCALE, default 6: clk12Mhz cycles per base tick (12 MHz -> 2 MHz).
REQ-003 SHALL have parameter PERIOD_W, default 16: width of channel period field.
REQ-004 SHALL have port clk12Mhz  input  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  scheduler can accept a request.
REQ-008 SHALL have port cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-009 SHALL have port cfg_period  input  PERIOD_W  period in base ticks; 0 means disable.
REQ-010 SHALL have port cfg_done  output  1  one-cycle pulse when the request has been applied.
REQ-011 SHALL have port base_tick  output  1  registered one-cycle pulse every PRESCALE cycles.
REQ-012 SHALL have port tick  output  NUM_CH  registered one-cycle pulse per channel.
REQ-013 SHALL have port active  output  NUM_CH  channel enabled (period != 0).

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and wrap; base_tick SHALL be high in the cycle after count == PRESCALE-1, i.e. first in cycle PRESCALE after reset release, then every PRESCALE cycles.
REQ-015 Configuration FSM states SHALL be IDLE, WAIT_BASE, DONE.
REQ-016 cfg_ready SHALL equal (state == IDLE) && !rst; accept SHALL occur when cfg_valid && cfg_ready; cfg_ch/cfg_period SHALL be latched on accept.
REQ-017 IDLE -> WAIT_BASE on accept; WAIT_BASE -> DONE on the cycle the prescaler wraps, applying the config that cycle; DONE -> IDLE unconditionally; cfg_done SHALL be high exactly during DONE.
REQ-018 Applying SHALL load the channel period, clear its counter to 0, set active[ch] = (period != 0).
REQ-019 On each prescaler wrap, each active channel not being applied SHALL: if counter == period-1, clear counter and raise tick[i] the next cycle; else increment counter.
REQ-020 First tick after application SHALL occur period base ticks later; period 1 SHALL tick on every base tick.
REQ-021 Applying to a channel on a wrap where it would fire SHALL suppress that tick (new config wins).
REQ-022 Inactive channels SHALL hold counter 0 and never tick.
REQ-023 cfg_valid while cfg_ready low SHALL be ignored, not queued.
REQ-024 Channel counters SHALL be PERIOD_W wide; no overflow possible since counter < period.

Reset
REQ-025 During rst: prescaler 0, all counters 0, periods 0, active 0, tick 0, base_tick 0, cfg_done 0, state IDLE, cfg_ready 0.
REQ-026 rst mid-operation SHALL discard any pending request without cfg_done.

Configuration
REQ-027 Macro TICK_SCHEDULER_PAUSE_EN SHALL, when defined, add input pause (1 bit): while high, prescaler and channel counters freeze, base_tick and tick stay 0, FSM waits in WAIT_BASE; counting resumes from held values on release.
REQ-028 Without TICK_SCHEDULER_PAUSE_EN the pause port SHALL not exist and counting SHALL never stall.

Structure
REQ-029 Package tick_scheduler_pkg SHALL hold the FSM state enum and default constants NUM_CH, PRESCALE, PERIOD_W.
REQ-030 Prescaler SHALL be sub-module tick_prescaler (count, wrap strobe, base_tick register, pause input).

Verification
REQ-031 Reset release, no config -> base_tick at cycles 6, 12, 18; tick == 0, active == 0.
REQ-032 cfg ch0 period 3 at cycle 2 -> cfg_done in the cycle after the wrap at cycle 5; tick[0] every 18 cycles, first 18 cycles after application.
REQ-033 ch1 period 1, ch2 period 2 -> tick[1] every 6 cycles, tick[2] every 12; independent, no interference.
REQ-034 Reconfigure ch0 period 3 -> 5 on its firing wrap -> no tick that wrap; next tick 5 base ticks (30 cycles) later; cfg_period 0 -> active[0] 0, no further ticks.
REQ-035 cfg_valid held high while FSM in WAIT_BASE with different cfg_ch -> second request accepted only after return to IDLE; rst asserted in WAIT_BASE -> no cfg_done, all channels inactive.
REQ-036 With TICK_SCHEDULER_PAUSE_EN: pause high 10 cycles mid-period -> no base_tick/tick during pause; next tick delayed exactly 10 cycles.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - shared defaults and configuration FSM state type for tick_scheduler
package tick_scheduler_pkg;

   localparam int DEFAULT_NUM_CH   = 4;
   localparam int DEFAULT_PRESCALE = 6;
   localparam int DEFAULT_PERIOD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BASE = 2'd1,
      ST_DONE      = 2'd2
   } cfg_state_e;

   // Counter width that stays legal for degenerate sizes of 0 or 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - base-tick prescaler: counts 0..PRESCALE-1, wrap strobe, registered base_tick
// pause_i freezes the count and suppresses wrap (driven only when TICK_SCHEDULER_PAUSE_EN is defined).
module tick_prescaler
   import tick_scheduler_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pause_i,
   output logic wrap_o,
   output logic base_tick_o
);

   localparam int               CNT_W = cnt_width(PRESCALE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             base_tick_q, base_tick_d;
   logic             wrap;

   always_comb begin
      wrap        = (count_q == LAST) && !pause_i;
      count_d     = count_q;
      base_tick_d = wrap;
      if (!pause_i) begin
         count_d = wrap ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q     <= '0;
         base_tick_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         base_tick_q <= base_tick_d;
      end
   end

   assign wrap_o      = wrap;
   assign base_tick_o = base_tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel periodic tick scheduler with handshake-based channel configuration
// Optional TICK_SCHEDULER_PAUSE_EN adds a pause input that freezes all counting.
module tick_scheduler
   import tick_scheduler_pkg::*;
#(
   parameter int NUM_CH   = DEFAULT_NUM_CH,
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
   input  logic                      clk12Mhz,
   input  logic                      rst,
`ifdef TICK_SCHEDULER_PAUSE_EN
   input  logic                      pause,
`endif
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [PERIOD_W-1:0]       cfg_period,
   output logic                      cfg_done,
   output logic                      base_tick,
   output logic [NUM_CH-1:0]         tick,
   output logic [NUM_CH-1:0]         active
);

   localparam int CH_W = $clog2(NUM_CH);

   logic pause_w;
   logic wrap;
   logic apply;
   logic accept;

`ifdef TICK_SCHEDULER_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_i       (clk12Mhz),
      .rst_i       (rst),
      .pause_i     (pause_w),
      .wrap_o      (wrap),
      .base_tick_o (base_tick)
   );

   cfg_state_e                state_q, state_d;
   logic [CH_W-1:0]           ch_q, ch_d;
   logic [PERIOD_W-1:0]       lat_period_q, lat_period_d;

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      lat_period_d = lat_period_q;
      cfg_ready    = (state_q == ST_IDLE) && !rst;
      cfg_done     = (state_q == ST_DONE);
      accept       = cfg_valid && cfg_ready;
      apply        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_WAIT_BASE;
               ch_d         = cfg_ch;
               lat_period_d = cfg_period;
            end
         end
         ST_WAIT_BASE: begin
            if (wrap) begin
               apply   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk12Mhz) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         lat_period_q <= '0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         lat_period_q <= lat_period_d;
      end
   end

   logic [NUM_CH-1:0][PERIOD_W-1:0] period_q, period_d;
   logic [NUM_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]               active_q, active_d;
   logic [NUM_CH-1:0]               tick_q, tick_d;

   // A channel being applied on a wrap takes the new config and skips its own advance.
   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      tick_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (apply && (ch_q == CH_W'(i))) begin
            period_d[i] = lat_period_q;
            cnt_d[i]    = '0;
            active_d[i] = |lat_period_q;
         end else if (wrap && active_q[i]) begin
            if (cnt_q[i] == period_q[i] - PERIOD_W'(1)) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk12Mhz) begin
      if (rst) begin
         period_q <= '0;
         cnt_q    <= '0;
         active_q <= '0;
         tick_q   <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         tick_q   <= tick_d;
      end
   end

   assign tick   = tick_q;
   assign active = active_q;

endmodule
